// File: rtl/alu_req_seq_if.sv
// Handshake and ALU-side bundle for the ALU request sequencer.
// slave = the sequencer itself, master = the decode/ALU/consumer environment.
interface alu_req_seq_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  imm;

    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [3:0]       alu_asel;
    logic [XLEN-1:0]  alu_out;
    logic             alu_cf;
    logic             alu_ov;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic             rsp_taken;
    logic             rsp_cf;
    logic             rsp_ov;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm,
        input  alu_out, alu_cf, alu_ov, alu_zero,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_asel,
        output rsp_valid, rsp_result, rsp_taken, rsp_cf, rsp_ov, rsp_zero, rsp_illegal,
        output op_count
    );

    modport master (
        output req_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm,
        output alu_out, alu_cf, alu_ov, alu_zero,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_asel,
        input  rsp_valid, rsp_result, rsp_taken, rsp_cf, rsp_ov, rsp_zero, rsp_illegal,
        input  op_count
    );
endinterface

// File: rtl/alu_req_seq.sv
// Request-side sequencer for the 32-bit combinational ALU: decodes a request,
// holds the ALU operands in registers, captures result/flags and returns a response.
module alu_req_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_req_seq_if.slave bus
);
    // state  | meaning
    // S_IDLE | ready for a request; decode and register ALU inputs on accept
    // S_EXEC | ALU inputs stable; capture result, flags and branch outcome
    // S_RESP | response held until rsp_ready
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [3:0] ASEL_AND = 4'b0000;
    localparam logic [3:0] ASEL_OR  = 4'b0001;
    localparam logic [3:0] ASEL_ADD = 4'b0010;
    localparam logic [3:0] ASEL_SUB = 4'b0110;
    localparam logic [3:0] ASEL_SLT = 4'b0111;
    localparam logic [3:0] ASEL_EQ  = 4'b1111;

    state_t           r_state;
    logic             r_req_ready;
    logic [XLEN-1:0]  r_alu_a;
    logic [XLEN-1:0]  r_alu_b;
    logic [3:0]       r_alu_asel;
    logic             r_is_br;
    logic             r_br_inv;
    logic             r_rsp_valid;
    logic [XLEN-1:0]  r_rsp_result;
    logic             r_rsp_taken;
    logic             r_rsp_cf;
    logic             r_rsp_ov;
    logic             r_rsp_zero;
    logic             r_rsp_illegal;
    logic [CNT_W-1:0] r_op_count;

    logic             w_legal;
    logic [3:0]       w_asel;
    logic             w_use_imm;
    logic             w_is_br;
    logic             w_br_inv;
    logic [XLEN-1:0]  w_operand_b;

    always_comb begin
        w_legal   = 1'b1;
        w_asel    = ASEL_ADD;
        w_use_imm = 1'b0;
        w_is_br   = 1'b0;
        w_br_inv  = 1'b0;
        case (bus.opcode)
            OP_R: begin
                case (bus.funct3)
                    3'b000:  w_asel = bus.funct7_5 ? ASEL_SUB : ASEL_ADD;
                    3'b111:  w_asel = ASEL_AND;
                    3'b110:  w_asel = ASEL_OR;
                    3'b010:  w_asel = ASEL_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_I: begin
                w_use_imm = 1'b1;
                case (bus.funct3)
                    3'b000:  w_asel = ASEL_ADD;
                    3'b111:  w_asel = ASEL_AND;
                    3'b110:  w_asel = ASEL_OR;
                    3'b010:  w_asel = ASEL_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                w_use_imm = 1'b1;
                w_asel    = ASEL_ADD;
            end
            OP_BR: begin
                // The ALU answers "equal" or "less than" in bit 0; BNE/BGE invert it.
                w_is_br = 1'b1;
                case (bus.funct3)
                    3'b000:  w_asel = ASEL_EQ;
                    3'b001: begin
                        w_asel   = ASEL_EQ;
                        w_br_inv = 1'b1;
                    end
                    3'b100:  w_asel = ASEL_SLT;
                    3'b101: begin
                        w_asel   = ASEL_SLT;
                        w_br_inv = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_operand_b = w_use_imm ? bus.imm : bus.rs2_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_asel    <= 4'b0000;
            r_is_br       <= 1'b0;
            r_br_inv      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_taken   <= 1'b0;
            r_rsp_cf      <= 1'b0;
            r_rsp_ov      <= 1'b0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_op_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (w_legal) begin
                            r_alu_a    <= bus.rs1_val;
                            r_alu_b    <= w_operand_b;
                            r_alu_asel <= w_asel;
                            r_is_br    <= w_is_br;
                            r_br_inv   <= w_br_inv;
                            r_state    <= S_EXEC;
                        end else begin
                            // Illegal encodings skip the ALU and leave its inputs untouched.
                            r_rsp_result  <= '0;
                            r_rsp_taken   <= 1'b0;
                            r_rsp_cf      <= 1'b0;
                            r_rsp_ov      <= 1'b0;
                            r_rsp_zero    <= 1'b0;
                            r_rsp_illegal <= 1'b1;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_result  <= bus.alu_out;
                    r_rsp_taken   <= r_is_br & (bus.alu_out[0] ^ r_br_inv);
                    r_rsp_cf      <= bus.alu_cf;
                    r_rsp_ov      <= bus.alu_ov;
                    r_rsp_zero    <= bus.alu_zero;
                    r_rsp_illegal <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                        if (!r_rsp_illegal) begin
                            r_op_count <= r_op_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_asel    = r_alu_asel;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_taken   = r_rsp_taken;
    assign bus.rsp_cf      = r_rsp_cf;
    assign bus.rsp_ov      = r_rsp_ov;
    assign bus.rsp_zero    = r_rsp_zero;
    assign bus.rsp_illegal = r_rsp_illegal;
    assign bus.op_count    = r_op_count;
endmodule
